lane_gather: RTL and testbench



---
 rtl/lane_gather_pkg.sv | 21 ++
 rtl/lane_dwell_counter.sv | 37 +++
 rtl/lane_gather.sv | 99 +++++++++
 tb/tb_lane_gather.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lane_gather_pkg.sv
// Shared types and parameter helpers for the lane gatherer and its dwell counter.
package lane_gather_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam int unsigned MIN_LANES = 2;
  localparam int unsigned MIN_DWELL = 1;

  function automatic bit params_ok(input int unsigned lanes, input int unsigned dwell);
    return (lanes >= MIN_LANES) && (dwell >= MIN_DWELL);
  endfunction

  // Dwell counter needs at least one bit even when DWELL == 1.
  function automatic int unsigned cnt_width(input int unsigned dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/lane_dwell_counter.sv
// Holds the lane index for DWELL cycles per lane while run is high; strobes the
// sample cycle and flags the last lane. Wraps to lane 0 after the last sample.
module lane_dwell_counter
  import lane_gather_pkg::*;
#(
  parameter  int unsigned LANES = 4,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned ADR_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             run,
  output logic [ADR_W-1:0] lane,
  output logic             sample_now_c,
  output logic             last_lane_c
);

  localparam int unsigned CNT_W = cnt_width(DWELL);

  logic [CNT_W-1:0] cnt;

  assign sample_now_c = run && (cnt == CNT_W'(DWELL - 1));
  assign last_lane_c  = (lane == ADR_W'(LANES - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt  <= '0;
      lane <= '0;
    end else if (sample_now_c) begin
      cnt  <= '0;
      lane <= last_lane_c ? '0 : lane + ADR_W'(1);
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lane_gather.sv
// Sweeps LANES muxed sources with a fixed dwell, packs the samples into one word
// and offers it on a valid/ready handshake with a sticky overrun flag.
module lane_gather
  import lane_gather_pkg::*;
#(
  parameter  int unsigned LANE_W = 8,
  parameter  int unsigned LANES  = 4,
  parameter  int unsigned DWELL  = 4,
  localparam int unsigned ADR_W  = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    mode,
  input  logic                    start,
  input  logic                    en,
  input  logic [LANE_W-1:0]       in,
  output logic [ADR_W-1:0]        adr,
  output logic [LANES*LANE_W-1:0] out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  if (!params_ok(LANES, DWELL)) begin : g_bad_params
    $error("lane_gather: LANES must be >= 2 and DWELL >= 1");
  end

  state_t state, state_nxt;
  logic   sample_now_c, last_lane_c, done_c;

  logic [LANES-2:0][LANE_W-1:0] lane_buf;
  logic [LANES-1:0][LANE_W-1:0] word_c;

  lane_dwell_counter #(
    .LANES (LANES),
    .DWELL (DWELL)
  ) u_cnt (
    .clk          (clk),
    .clr_n        (clr_n),
    .run          (state == ST_SWEEP),
    .lane         (adr),
    .sample_now_c (sample_now_c),
    .last_lane_c  (last_lane_c)
  );

  assign done_c = sample_now_c && last_lane_c;
  // Final lane goes straight into the word; earlier lanes come from the buffer.
  assign word_c = {in, lane_buf};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_SWEEP);
    end
  end

  // Mode/en are only looked at in IDLE and at the sweep end.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start || (mode && en)) state_nxt = ST_SWEEP;
      ST_SWEEP: if (done_c && !(mode && en)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      lane_buf <= '0;
    end else if (sample_now_c) begin
      for (int unsigned k = 0; k < LANES - 1; k++) begin
        if (adr == ADR_W'(k)) lane_buf[k] <= in;
      end
    end
  end

  // Completion wins over acceptance; overwriting an unaccepted word sets overrun over a clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (done_c) begin
      out       <= word_c;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
      else if (overrun_clr)        overrun <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (overrun_clr)            overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lane_gather.sv
// Directed bench for lane_gather: default build plus a 12-bit x 3-lane, dwell-1 build.
module tb_lane_gather;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n;

  // Default instance: LANE_W=8, LANES=4, DWELL=4
  logic        mode0, start0, en0, out_ready0, overrun_clr0;
  logic [7:0]  in0;
  logic [1:0]  adr0;
  logic [31:0] out0;
  logic        out_valid0, busy0, overrun0;
  logic [7:0]  lane_val0 [4];

  // Narrow instance: LANE_W=12, LANES=3, DWELL=1
  logic        start1, out_ready1;
  logic [11:0] in1;
  logic [1:0]  adr1;
  logic [35:0] out1;
  logic        out_valid1, busy1, overrun1;

  int vectors = 0;
  int miscompares = 0;

  lane_gather dut0 (
    .clk(clk), .clr_n(clr_n), .mode(mode0), .start(start0), .en(en0),
    .in(in0), .adr(adr0), .out(out0), .out_valid(out_valid0),
    .out_ready(out_ready0), .busy(busy0), .overrun(overrun0),
    .overrun_clr(overrun_clr0)
  );

  lane_gather #(.LANE_W(12), .LANES(3), .DWELL(1)) dut1 (
    .clk(clk), .clr_n(clr_n), .mode(1'b0), .start(start1), .en(1'b0),
    .in(in1), .adr(adr1), .out(out1), .out_valid(out_valid1),
    .out_ready(out_ready1), .busy(busy1), .overrun(overrun1),
    .overrun_clr(1'b0)
  );

  // Muxed peripheral models: each lane presents a fixed value chosen by the bench.
  assign in0 = lane_val0[adr0];
  always_comb begin
    case (adr1)
      2'd0:    in1 = 12'hABC;
      2'd1:    in1 = 12'h123;
      2'd2:    in1 = 12'hF0F;
      default: in1 = 12'h000;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clr_n = 1'b0;
    mode0 = 1'b0; start0 = 1'b0; en0 = 1'b0; out_ready0 = 1'b0; overrun_clr0 = 1'b0;
    start1 = 1'b0; out_ready1 = 1'b0;
    lane_val0[0] = 8'h11; lane_val0[1] = 8'h22; lane_val0[2] = 8'h33; lane_val0[3] = 8'h44;

    // Reset state
    #12;
    chk("rst_adr", 64'(adr0), 64'd0);
    chk("rst_out", 64'(out0), 64'd0);
    chk("rst_valid", 64'(out_valid0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_overrun", 64'(overrun0), 64'd0);
    chk("rst_out1", 64'(out1), 64'd0);
    clr_n = 1'b1;
    step(1);

    // One-shot sweep: adr dwells 4 cycles per lane, valid exactly 16 cycles after start
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    chk("os_busy", 64'(busy0), 64'd1);
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 4; d++) begin
        chk("os_adr", 64'(adr0), 64'(k));
        chk("os_valid_early", 64'(out_valid0), 64'd0);
        step(1);
      end
    end
    chk("os_valid", 64'(out_valid0), 64'd1);
    chk("os_out", 64'(out0), 64'h44332211);
    chk("os_busy_fall", 64'(busy0), 64'd0);
    chk("os_adr_idle", 64'(adr0), 64'd0);
    step(3);
    chk("os_hold_valid", 64'(out_valid0), 64'd1);
    chk("os_hold_out", 64'(out0), 64'h44332211);
    chk("os_hold_idle", 64'(busy0), 64'd0);
    out_ready0 = 1'b1;
    step(1);
    chk("os_accept", 64'(out_valid0), 64'd0);

    // Continuous mode, always ready: words every 16 cycles with no gap
    lane_val0[0] = 8'hAA; lane_val0[1] = 8'hBB; lane_val0[2] = 8'hCC; lane_val0[3] = 8'hDD;
    mode0 = 1'b1; en0 = 1'b1;
    step(1);
    step(15);
    chk("ct_valid_early", 64'(out_valid0), 64'd0);
    step(1);
    chk("ct_valid1", 64'(out_valid0), 64'd1);
    chk("ct_out1", 64'(out0), 64'hDDCCBBAA);
    chk("ct_busy_nogap", 64'(busy0), 64'd1);
    step(1);
    chk("ct_consumed", 64'(out_valid0), 64'd0);
    lane_val0[0] = 8'h01; lane_val0[1] = 8'h02; lane_val0[2] = 8'h03; lane_val0[3] = 8'h04;
    step(3);
    chk("ct_adr_lane1", 64'(adr0), 64'd1);
    step(11);
    chk("ct_valid2_early", 64'(out_valid0), 64'd0);
    step(1);
    chk("ct_valid2", 64'(out_valid0), 64'd1);
    chk("ct_out2", 64'(out0), 64'h04030201);
    chk("ct_no_overrun", 64'(overrun0), 64'd0);

    // Continuous mode, not ready: overwrite sets overrun; clear; clear vs set
    out_ready0 = 1'b0;
    lane_val0[0] = 8'h10; lane_val0[1] = 8'h20; lane_val0[2] = 8'h30; lane_val0[3] = 8'h40;
    step(15);
    chk("ov_stable_out", 64'(out0), 64'h04030201);
    chk("ov_none_yet", 64'(overrun0), 64'd0);
    step(1);
    chk("ov_set", 64'(overrun0), 64'd1);
    chk("ov_out", 64'(out0), 64'h40302010);
    chk("ov_valid", 64'(out_valid0), 64'd1);
    overrun_clr0 = 1'b1;
    step(1);
    overrun_clr0 = 1'b0;
    chk("ov_clr", 64'(overrun0), 64'd0);
    step(14);
    overrun_clr0 = 1'b1;
    step(1);
    overrun_clr0 = 1'b0;
    chk("ov_set_wins", 64'(overrun0), 64'd1);

    // Drop en mid-sweep: current sweep completes then IDLE
    en0 = 1'b0;
    step(15);
    chk("en_off_busy", 64'(busy0), 64'd1);
    step(1);
    chk("en_off_idle", 64'(busy0), 64'd0);
    chk("en_off_valid", 64'(out_valid0), 64'd1);
    out_ready0 = 1'b1; overrun_clr0 = 1'b1;
    step(1);
    chk("en_off_accept", 64'(out_valid0), 64'd0);
    chk("en_off_ovclr", 64'(overrun0), 64'd0);
    out_ready0 = 1'b0; overrun_clr0 = 1'b0; mode0 = 1'b0;

    // Reset pulse at cycle 7 of a one-shot sweep
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    step(6);
    chk("mr_busy_before", 64'(busy0), 64'd1);
    chk("mr_adr_before", 64'(adr0), 64'd1);
    clr_n = 1'b0;
    #1;
    chk("mr_adr", 64'(adr0), 64'd0);
    chk("mr_busy", 64'(busy0), 64'd0);
    chk("mr_out", 64'(out0), 64'd0);
    chk("mr_valid", 64'(out_valid0), 64'd0);
    chk("mr_overrun", 64'(overrun0), 64'd0);
    #2;
    clr_n = 1'b1;
    step(20);
    chk("mr_no_valid", 64'(out_valid0), 64'd0);
    chk("mr_idle", 64'(busy0), 64'd0);

    // Narrow build: valid 3 cycles after start, 12-bit lanes packed LSB first
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    chk("nw_busy", 64'(busy1), 64'd1);
    step(1);
    chk("nw_adr", 64'(adr1), 64'd1);
    step(1);
    chk("nw_valid_early", 64'(out_valid1), 64'd0);
    step(1);
    chk("nw_valid", 64'(out_valid1), 64'd1);
    chk("nw_out", 64'(out1), 64'hF0F123ABC);
    chk("nw_busy_fall", 64'(busy1), 64'd0);
    chk("nw_overrun", 64'(overrun1), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
